hack_rr_arbiter8: RTL and testbench

Eight-requester round-robin arbiter that shares a single Hack resource, such as a memory port or ALU slot, between up to eight masters. It issues a registered one-hot grant and holds it while the owner keeps its request asserted. A hold limit forces the grant to move on when other requesters are waiting. Its combinational "any request" term is an 8-way OR of `req`, the same reduction the gate library already provides, so the arbiter sits directly above that gate layer.

---
 rtl/hack_rr_arbiter8.sv | 108 ++++++++++
 tb/tb_hack_rr_arbiter8.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/hack_rr_arbiter8.sv
// Eight-requester round-robin arbiter with a registered one-hot grant.
// A hold limit moves the grant on when the owner has held it too long under contention.
module hack_rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       busy,
    output logic       any_req,
    output logic       preempt
);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hold_cnt;

    logic [2:0] next_start;
    logic [2:0] next_after;
    logic [2:0] after_id;
    logic       own_req;
    logic       others;
    logic       at_limit;

    // First index at or after s (mod 8) whose request is set; s if none.
    function automatic logic [2:0] next_idx(
        input logic [7:0] r,
        input logic [2:0] s
    );
        logic [2:0] k;
        next_idx = s;
        for (int n = 7; n >= 0; n--) begin
            k = s + 3'(n);
            if (r[k]) next_idx = k;
        end
    endfunction

    assign any_req    = |req;
    assign after_id   = grant_id + 3'd1;
    assign next_start = next_idx(req, ptr);
    assign next_after = next_idx(req, after_id);
    assign own_req    = req[grant_id];
    assign others     = |(req & ~grant);
    assign at_limit   = (hold_cnt == HOLD_LIM);

    // Arbitration state, pointer, hold counter and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 8'd0;
            grant_id <= 3'd0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
            ptr      <= 3'd0;
            hold_cnt <= 8'd0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= OWN;
                        grant    <= 8'd1 << next_start;
                        grant_id <= next_start;
                        busy     <= 1'b1;
                        hold_cnt <= 8'd0;
                    end
                end
                OWN: begin
                    if (!own_req) begin
                        ptr      <= after_id;
                        hold_cnt <= 8'd0;
                        if (any_req) begin
                            grant    <= 8'd1 << next_after;
                            grant_id <= next_after;
                        end else begin
                            state <= IDLE;
                            grant <= 8'd0;
                            busy  <= 1'b0;
                        end
                    end else if (at_limit && others) begin
                        ptr      <= after_id;
                        hold_cnt <= 8'd0;
                        grant    <= 8'd1 << next_after;
                        grant_id <= next_after;
                        preempt  <= 1'b1;
                    end else if (!at_limit) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 8'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_rr_arbiter8.sv
// Directed self-checking bench for hack_rr_arbiter8 with HOLD_MAX = 4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_hack_rr_arbiter8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       busy;
    logic       any_req;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    hack_rr_arbiter8 #(.HOLD_MAX(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .any_req  (any_req),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'hFF;
        @(negedge clk);
        step();

        // reset holds everything at zero despite full request
        chk("rst_grant", 32'(grant), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_preempt", 32'(preempt), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_any_req", 32'(any_req), 32'h1);

        // single requester 3
        req   = 8'h08;
        reset = 1'b0;
        step();
        chk("single_grant", 32'(grant), 32'h08);
        chk("single_id", 32'(grant_id), 32'h3);
        chk("single_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("single_hold", 32'(grant), 32'h08);
            chk("single_nopre", 32'(preempt), 32'h0);
        end
        req = 8'h00;
        chk("any_req_zero", 32'(any_req), 32'h0);
        step();
        chk("single_rel_grant", 32'(grant), 32'h00);
        chk("single_rel_busy", 32'(busy), 32'h0);

        // full-load rotation from index 0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = 8'hFF;
        for (int c = 0; c < 36; c++) begin
            step();
            chk("rot_grant", 32'(grant), 32'(8'd1 << ((c / 4) % 8)));
            chk("rot_id", 32'(grant_id), 32'((c / 4) % 8));
            chk("rot_preempt", 32'(preempt), 32'((c % 4 == 0) && (c != 0)));
        end

        // gapless handoff 5 -> 6 -> 2
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = 8'h20;
        step();
        chk("gap_own5", 32'(grant), 32'h20);
        req = 8'h64;
        step();
        chk("gap_hold5", 32'(grant), 32'h20);
        req = 8'h44;
        step();
        chk("gap_to6", 32'(grant), 32'h40);
        chk("gap_to6_busy", 32'(busy), 32'h1);
        chk("gap_to6_pre", 32'(preempt), 32'h0);
        req = 8'h04;
        step();
        chk("gap_to2", 32'(grant), 32'h04);
        chk("gap_to2_id", 32'(grant_id), 32'h2);
        chk("gap_to2_pre", 32'(preempt), 32'h0);

        // wrap 7 -> 1, then uncontended hold
        req = 8'h80;
        step();
        chk("wrap_own7", 32'(grant), 32'h80);
        req = 8'h02;
        step();
        chk("wrap_to1", 32'(grant), 32'h02);
        chk("wrap_to1_id", 32'(grant_id), 32'h1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("solo_grant", 32'(grant), 32'h02);
            chk("solo_nopre", 32'(preempt), 32'h0);
        end

        // asynchronous reset mid-grant, then restart from index 0
        req = 8'h20;
        step();
        chk("mid_own5", 32'(grant), 32'h20);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'h00);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        req   = 8'h21;
        reset = 1'b0;
        step();
        chk("post_rst_grant", 32'(grant), 32'h01);
        chk("post_rst_id", 32'(grant_id), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
